// File: rtl/display_pkg.sv
// display_pkg: segment and anode encodings shared by the seven-segment display blocks.
package display_pkg;
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_ONES  = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: BCD digit to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);
    always_comb begin
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/guess_count_display.sv
// guess_count_display: resynchronises the async BCD guess count and scans it onto a
// 2-digit multiplexed active-low display with blanking, dash and win-blink modes.
module guess_count_display
    import display_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYC    = 500,
    parameter int BLINK_SLOTS = 100,
    parameter bit LZB         = 1'b1
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [3:0] count0,
    input  logic [3:0] count1,
    input  logic       win,
    output logic [6:0] seg,
    output logic [1:0] an
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_SLOTS + 1);

    logic [8:0]    sync1_q, sync2_q, sync3_q;
    logic [3:0]    disp0_q, disp0_d, disp1_q, disp1_d, digit;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          sel_q, sel_d, phase_q, phase_d, wrap, blink_end, blank;
    logic [6:0]    seg_q, seg_d, dec_seg;
    logic [1:0]    an_q, an_d;

    bcd_to_7seg u_dec (.digit_i(digit), .seg_o(dec_seg));

    assign digit = sel_d ? disp1_d : disp0_d;

    // Outputs are decoded from next-state values so the pins line up with the prescaler.
    always_comb begin
        wrap      = presc_q == PW'(SCAN_DIV - 1);
        presc_d   = wrap ? '0 : presc_q + 1'b1;
        sel_d     = sel_q ^ wrap;
        disp0_d   = (sync2_q == sync3_q) ? sync2_q[3:0] : disp0_q;
        disp1_d   = (sync2_q == sync3_q) ? sync2_q[7:4] : disp1_q;
        blink_end = blink_q == BW'(BLINK_SLOTS - 1);
        blink_d   = !sync2_q[8] ? '0 : !wrap ? blink_q : blink_end ? '0 : blink_q + 1'b1;
        phase_d   = !sync2_q[8] || (phase_q ^ (wrap && blink_end));
        blank     = sel_d && LZB && disp1_d == 4'd0;
        an_d      = (presc_d < PW'(DEAD_CYC) || !phase_d || blank) ? AN_OFF
                  : sel_d ? AN_TENS : AN_ONES;
        seg_d     = blank ? SEG_OFF : dec_seg;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            disp0_q <= '0;
            disp1_q <= '0;
            presc_q <= '0;
            sel_q   <= 1'b0;
            blink_q <= '0;
            phase_q <= 1'b1;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            sync1_q <= {win, count1, count0};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            disp0_q <= disp0_d;
            disp1_q <= disp1_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
endmodule

// File: tb/tb_guess_count_display.sv
// tb_guess_count_display: table-driven and randomized checks of the scanned display
// against a slot/cycle reference model derived from the display rules.
module tb_guess_count_display;
    logic       clk = 1'b0;
    logic       Reset;
    logic [3:0] count0, count1;
    logic       win;
    logic [6:0] seg;
    logic [1:0] an;
    int         cyc;
    int         checks = 0;
    int         errors = 0;

    guess_count_display #(.SCAN_DIV(4), .DEAD_CYC(1), .BLINK_SLOTS(2), .LZB(1'b1)) dut (
        .clk(clk), .Reset(Reset), .count0(count0), .count1(count1), .win(win),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release: scan position is cyc % 4, tens slot when (cyc / 4) is odd.
    always @(posedge clk or negedge Reset)
        if (!Reset) cyc <= 0;
        else cyc <= cyc + 1;

    typedef struct {
        string      nm;
        logic [3:0] c0, c1;
        logic [6:0] so, st;
        bit         tb;
    } vec_t;

    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] pat(input logic [3:0] d);
        return d > 4'd9 ? 7'h3F : tbl[d];
    endfunction

    task automatic check_cycles(input string nm, input logic [6:0] so, input logic [6:0] st,
                                input bit tb, input bit on, input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0] ea;
            logic [6:0] es;
            bit tens, care;
            @(negedge clk);
            tens = ((cyc / 4) % 2) == 1;
            if (tens && tb) begin
                ea = 2'b11;
                es = 7'h7F;
                care = 1'b1;
            end else begin
                ea = (cyc % 4 == 0 || !on) ? 2'b11 : tens ? 2'b01 : 2'b10;
                es = tens ? st : so;
                care = ea != 2'b11;
            end
            checks++;
            if (an !== ea) begin
                errors++;
                $display("FAIL %s an cyc %0d got %b exp %b", nm, cyc, an, ea);
            end
            if (care) begin
                checks++;
                if (seg !== es) begin
                    errors++;
                    $display("FAIL %s seg cyc %0d got %h exp %h", nm, cyc, seg, es);
                end
            end
        end
    endtask

    task automatic set_count(input logic [3:0] c0, input logic [3:0] c1);
        count0 = c0;
        count1 = c1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        vec_t vecs [8];
        int act [8];
        bit found;
        vecs[0] = '{"v37",   4'd7, 4'd3, 7'h78, 7'h30, 1'b0};
        vecs[1] = '{"v05",   4'd5, 4'd0, 7'h12, 7'h7F, 1'b1};
        vecs[2] = '{"vC1",   4'hC, 4'd1, 7'h3F, 7'h79, 1'b0};
        vecs[3] = '{"v99",   4'd9, 4'd9, 7'h10, 7'h10, 1'b0};
        vecs[4] = '{"v00",   4'd0, 4'd0, 7'h40, 7'h7F, 1'b1};
        vecs[5] = '{"v20",   4'd0, 4'd2, 7'h40, 7'h24, 1'b0};
        vecs[6] = '{"vAF",   4'hF, 4'hA, 7'h3F, 7'h3F, 1'b0};
        vecs[7] = '{"v68",   4'd8, 4'd6, 7'h00, 7'h02, 1'b0};
        Reset = 1'b0;
        count0 = 4'd0;
        count1 = 4'd0;
        win = 1'b0;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        check_cycles("rst_zero", 7'h40, 7'h7F, 1'b1, 1'b1, 8);
        for (int v = 0; v < 8; v++) begin
            set_count(vecs[v].c0, vecs[v].c1);
            check_cycles(vecs[v].nm, vecs[v].so, vecs[v].st, vecs[v].tb, 1'b1, 8);
        end
        set_count(4'd7, 4'd3);
        for (int i = 0; i < 20; i++) begin
            {count1, count0} = (i % 2 == 0) ? 8'h19 : 8'h20;
            check_cycles("skew_hold", 7'h78, 7'h30, 1'b0, 1'b1, 1);
        end
        {count1, count0} = 8'h20;
        repeat (11) @(negedge clk);
        check_cycles("skew_settle", 7'h40, 7'h24, 1'b0, 1'b1, 8);
        set_count(4'd7, 4'd3);
        @(negedge clk);
        #1 Reset = 1'b0;
        #1;
        checks += 2;
        if (an !== 2'b11) begin
            errors++;
            $display("FAIL async_rst an got %b exp 11", an);
        end
        if (seg !== 7'h7F) begin
            errors++;
            $display("FAIL async_rst seg got %h exp 7f", seg);
        end
        @(negedge clk);
        Reset = 1'b1;
        check_cycles("rst_clear", 7'h40, 7'h7F, 1'b1, 1'b1, 3);
        repeat (8) @(negedge clk);
        check_cycles("rst_resume", 7'h78, 7'h30, 1'b0, 1'b1, 8);
        for (int r = 0; r < 20; r++) begin
            logic [3:0] c0, c1;
            c0 = 4'($urandom_range(0, 15));
            c1 = 4'($urandom_range(0, 15));
            set_count(c0, c1);
            check_cycles("rand", pat(c0), pat(c1), c1 == 4'd0, 1'b1, 8);
        end
        set_count(4'd2, 4'd4);
        win = 1'b1;
        repeat (8) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            found = cyc % 4 == 3;
        end
        for (int s = 0; s < 8; s++) begin
            act[s] = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (an !== 2'b11) act[s]++;
            end
            checks++;
            if (act[s] != 0 && act[s] != 3) begin
                errors++;
                $display("FAIL blink_slot %0d got %0d lit cycles exp 0 or 3", s, act[s]);
            end
        end
        for (int s = 0; s < 4; s++) begin
            checks += 2;
            if ((act[s] != 0) != (act[s + 4] != 0)) begin
                errors++;
                $display("FAIL blink_period slot %0d got %0d exp %0d", s, act[s + 4], act[s]);
            end
            if ((act[s] != 0) == (act[s + 2] != 0)) begin
                errors++;
                $display("FAIL blink_half slot %0d got %0d vs %0d exp differing", s, act[s + 2], act[s]);
            end
        end
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge clk);
            found = cyc % 4 == 2 && an === 2'b11;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL blink_off_seek got none exp off slot");
        end
        win = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            found = an !== 2'b11;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL win_release an stayed 11 exp lit within 6 cycles");
        end
        repeat (4) @(negedge clk);
        check_cycles("win_off", 7'h12 ^ 7'h12 ^ 7'h24, 7'h19, 1'b0, 1'b1, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
